feature_stream_packer: RTL and testbench

FEATURE_STREAM_PACKER -- requirements
Module: feature_stream_packer

---
 rtl/feature_stream_pkg.sv | 29 ++
 rtl/feature_stream_packer_fifo.sv | 55 +++++
 rtl/feature_stream_packer.sv | 163 ++++++++++++++++
 tb/tb_feature_stream_packer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/feature_stream_pkg.sv
// Shared types for the feature stream packer:
// buffered entry layout, trailer tag and serializer states.
package feature_stream_pkg;

  localparam int         MAX_COORD_BITS    = 16;
  localparam int         DESC_BITS         = 256;
  localparam logic [7:0] TRAILER_TAG       = 8'hA5;
  localparam int         WORDS_PER_FEATURE = 9;

  // has_feature sits at the MSB so the FIFO can peek it cheaply
  typedef struct packed {
    logic                      has_feature;
    logic                      end_frame;
    logic                      dropped;
    logic [MAX_COORD_BITS-1:0] x;
    logic [MAX_COORD_BITS-1:0] y;
    logic [DESC_BITS-1:0]      descriptor;
  } entry_t;

  localparam int ENTRY_BITS = $bits(entry_t);

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    DESC,
    TRAILER
  } state_t;

endpackage

// File: rtl/feature_stream_packer_fifo.sv
// Synchronous FIFO with registered read data,
// occupancy count and a combinational peek of the head's top bits.
module feature_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int PEEK_BITS = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic [PEEK_BITS-1:0]   peek,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign peek  = mem[rd_ptr][WIDTH-1 -: PEEK_BITS];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr];
      end
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  end

endmodule

// File: rtl/feature_stream_packer.sv
// Buffers detected features and serializes them as 32-bit words,
// closing each frame with a tagged trailer carrying count and drop flag.
module feature_stream_packer
  import feature_stream_pkg::*;
#(
  parameter int COORD_BITS      = 10,
  parameter int DESCRIPTOR_BITS = 256,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [COORD_BITS-1:0]      in_feature_x,
  input  logic [COORD_BITS-1:0]      in_feature_y,
  input  logic [DESCRIPTOR_BITS-1:0] in_descriptor,
  input  logic                       in_frame_end,
  output logic [31:0]                out_word,
  output logic                       out_valid,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic                       out_overflow
);

  localparam int         CW        = $clog2(FIFO_DEPTH) + 1;
  localparam int         OW        = CW + 1;
  localparam logic [2:0] DESC_LAST = 3'(WORDS_PER_FEATURE - 2);

  state_t        state;
  state_t        state_n;
  state_t        load_state;
  logic [2:0]    idx;
  logic [2:0]    idx_n;
  logic [15:0]   feat_cnt;
  logic          frame_dropped;
  entry_t        wr_entry;
  entry_t        cur;
  logic [0:0]    peek;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic [OW-1:0] occ;
  logic          accept;
  logic          push_feat;
  logic          drop_now;
  logic          push;
  logic          pop;
  logic          hs;
  logic          last_word;

  // the entry being serialized still holds a buffer slot
  assign occ       = OW'(fifo_count) + OW'(state != IDLE);
  assign accept    = (occ < OW'(FIFO_DEPTH - 1));
  assign push_feat = !reset && in_valid && accept;
  assign drop_now  = !reset && in_valid && !accept;
  assign push      = !reset && (push_feat || in_frame_end);

  always_comb begin
    wr_entry             = '0;
    wr_entry.has_feature = push_feat;
    wr_entry.end_frame   = in_frame_end;
    wr_entry.dropped     = frame_dropped || drop_now;
    wr_entry.x           = MAX_COORD_BITS'(in_feature_x);
    wr_entry.y           = MAX_COORD_BITS'(in_feature_y);
    wr_entry.descriptor  = in_descriptor;
  end

  feature_fifo #(
    .WIDTH     (ENTRY_BITS),
    .DEPTH     (FIFO_DEPTH),
    .PEEK_BITS (1)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (cur),
    .peek    (peek),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_valid = (state != IDLE);
  assign out_last  = (state == TRAILER);
  assign hs        = out_valid && out_ready;
  assign last_word = (state == TRAILER) ||
                     (state == DESC && idx == DESC_LAST && !cur.end_frame);
  // next entry is loaded on the same edge the current one finishes
  assign pop        = !reset && !fifo_empty &&
                      (state == IDLE || (hs && last_word));
  assign load_state = peek[0] ? HEADER : TRAILER;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    unique case (state)
      IDLE: begin
        if (pop) state_n = load_state;
      end
      HEADER: begin
        if (hs) begin
          state_n = DESC;
          idx_n   = '0;
        end
      end
      DESC: begin
        if (hs) begin
          if (idx != DESC_LAST) idx_n = idx + 3'd1;
          else if (cur.end_frame) state_n = TRAILER;
          else state_n = pop ? load_state : IDLE;
        end
      end
      TRAILER: begin
        if (hs) state_n = pop ? load_state : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    out_word = '0;
    unique case (state)
      HEADER:  out_word = (32'(cur.y) << COORD_BITS) | 32'(cur.x);
      DESC:    out_word = cur.descriptor[{idx, 5'b0} +: 32];
      TRAILER: out_word = {TRAILER_TAG, 7'b0, cur.dropped, feat_cnt};
      default: out_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      feat_cnt <= '0;
    end else if (hs && state == TRAILER) begin
      feat_cnt <= '0;
    end else if (hs && state == HEADER && cur.has_feature &&
                 feat_cnt != 16'hFFFF) begin
      feat_cnt <= feat_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_dropped <= 1'b0;
      out_overflow  <= 1'b0;
    end else begin
      if (in_frame_end) frame_dropped <= 1'b0;
      else if (drop_now) frame_dropped <= 1'b1;
      if (drop_now) out_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_feature_stream_packer.sv
// Self-checking bench: queue-based word model plus directed literal checks
// and a randomized stall/traffic run.
module tb_feature_stream_packer;

  localparam int C     = 10;
  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_frame_end = 1'b0;
  logic         out_ready = 1'b0;
  logic [C-1:0] in_feature_x = '0;
  logic [C-1:0] in_feature_y = '0;
  logic [255:0] in_descriptor = '0;
  logic [31:0]  out_word;
  logic         out_valid;
  logic         out_last;
  logic         out_overflow;

  always #5 clk = ~clk;

  feature_stream_packer #(
    .COORD_BITS      (C),
    .DESCRIPTOR_BITS (256),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_feature_x  (in_feature_x),
    .in_feature_y  (in_feature_y),
    .in_descriptor (in_descriptor),
    .in_frame_end  (in_frame_end),
    .out_word      (out_word),
    .out_valid     (out_valid),
    .out_last      (out_last),
    .out_ready     (out_ready),
    .out_overflow  (out_overflow)
  );

  typedef struct {
    logic [31:0] w;
    bit          last;
    bit          ends;
    int          pe;
  } exp_t;

  int          tests = 0;
  int          fails = 0;
  exp_t        exp_q[$];
  logic [31:0] log_w[$];
  bit          log_l[$];
  int          level = 0;
  int          edge_n = 0;
  int          frame_feats = 0;
  bit          frame_drop = 1'b0;
  bit          ovf = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_w;
  logic        prev_l;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // Model: every buffered entry becomes its list of words at push time;
  // buffer level counts entries pushed but not fully handed off.
  always @(negedge clk) begin
    bit          acc;
    bit          hs;
    bit          feat;
    exp_t        e;
    logic [31:0] w0;
    edge_n++;
    if (reset) begin
      exp_q.delete();
      level       = 0;
      frame_feats = 0;
      frame_drop  = 1'b0;
      ovf         = 1'b0;
      prev_stall  = 1'b0;
    end else begin
      check("overflow", 32'(out_overflow), 32'(ovf));
      if (exp_q.size() == 0)
        check("idle_valid", 32'(out_valid), 32'd0);
      else if (edge_n - exp_q[0].pe >= 2)
        check("no_bubble_valid", 32'(out_valid), 32'd1);
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_word", out_word, prev_w);
        check("stall_last", 32'(out_last), 32'(prev_l));
      end
      acc = (level < DEPTH - 1);
      hs  = out_valid && out_ready;
      if (hs) begin
        log_w.push_back(out_word);
        log_l.push_back(out_last);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_word: got %h, expected no word", out_word);
        end else begin
          e = exp_q.pop_front();
          check("word", out_word, e.w);
          check("last", 32'(out_last), 32'(e.last));
          if (e.ends) level--;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_w     = out_word;
      prev_l     = out_last;
      feat = in_valid && acc;
      if (in_valid && !acc) begin
        ovf        = 1'b1;
        frame_drop = 1'b1;
      end
      if (feat || in_frame_end) level++;
      if (feat) begin
        frame_feats++;
        w0 = (32'(in_feature_y) << C) | 32'(in_feature_x);
        for (int k = 0; k < 9; k++) begin
          if (k == 0) e.w = w0;
          else e.w = in_descriptor[32*(k-1) +: 32];
          e.last = 1'b0;
          e.ends = (k == 8) && !in_frame_end;
          e.pe   = edge_n;
          exp_q.push_back(e);
        end
      end
      if (in_frame_end) begin
        e.w    = {8'hA5, 7'b0, frame_drop, 16'(frame_feats)};
        e.last = 1'b1;
        e.ends = 1'b1;
        e.pe   = edge_n;
        exp_q.push_back(e);
        frame_feats = 0;
        frame_drop  = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset        = 1'b1;
    in_valid     = 1'b0;
    in_frame_end = 1'b0;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic rand_desc(output logic [255:0] d);
    for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
  endtask

  task automatic drive_feature(input logic [C-1:0] x, input logic [C-1:0] y,
                               input logic [255:0] d, input bit fe);
    in_valid      = 1'b1;
    in_feature_x  = x;
    in_feature_y  = y;
    in_descriptor = d;
    in_frame_end  = fe;
    tick();
    in_valid     = 1'b0;
    in_frame_end = 1'b0;
  endtask

  task automatic drive_rand_feature(input bit fe);
    logic [255:0] d;
    rand_desc(d);
    drive_feature(C'($urandom_range(0, 1023)), C'($urandom_range(0, 1023)),
                  d, fe);
  endtask

  task automatic frame_end();
    in_frame_end = 1'b1;
    tick();
    in_frame_end = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0 || out_valid) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending words, expected 0",
               exp_q.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] d;
    int           base;
    int           n;

    // reset state
    do_reset(3);
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_word", out_word, 32'd0);
    check("rst_overflow", 32'(out_overflow), 32'd0);
    tick();

    // single feature, latency and word order
    for (int i = 0; i < 32; i++) d[255-8*i -: 8] = 8'(i + 1);
    out_ready = 1'b1;
    base = log_w.size();
    drive_feature(C'(5), C'(7), d, 1'b0);
    @(negedge clk);
    check("lat_cycle1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_cycle2_valid", 32'(out_valid), 32'd1);
    check("lat_cycle2_word", out_word, 32'h00001C05);
    drain(100);
    check("t1_count", 32'(log_w.size() - base), 32'd9);
    check("t1_desc_lsw", log_w[base+1], 32'h1D1E1F20);
    check("t1_desc_msw", log_w[base+8], 32'h01020304);

    // three features then a lone frame end
    do_reset(2);
    out_ready = 1'b1;
    base = log_w.size();
    repeat (3) drive_rand_feature(1'b0);
    frame_end();
    drain(200);
    check("t2_count", 32'(log_w.size() - base), 32'd28);
    check("t2_trailer", log_w[base+27], 32'hA5000003);
    check("t2_trailer_last", 32'(log_l[base+27]), 32'd1);
    check("t2_feat_last", 32'(log_l[base+26]), 32'd0);

    // feature coincident with frame end
    do_reset(2);
    out_ready = 1'b1;
    base = log_w.size();
    drive_rand_feature(1'b1);
    drain(100);
    check("t3_count", 32'(log_w.size() - base), 32'd10);
    check("t3_trailer", log_w[base+9], 32'hA5000001);

    // overflow under stalled output
    do_reset(2);
    out_ready = 1'b0;
    base = log_w.size();
    repeat (20) tick();
    repeat (20) drive_rand_feature(1'b0);
    frame_end();
    @(negedge clk);
    check("t4_overflow", 32'(out_overflow), 32'd1);
    tick();
    drain(400);
    check("t4_count", 32'(log_w.size() - base), 32'd136);
    check("t4_trailer", log_w[log_w.size()-1], 32'hA501000F);

    // reset in the middle of a descriptor
    do_reset(2);
    out_ready = 1'b1;
    base = log_w.size();
    drive_rand_feature(1'b0);
    n = 0;
    while (log_w.size() < base + 5 && n < 50) begin
      tick();
      n++;
    end
    check("t5_reached_desc4", 32'(log_w.size() - base), 32'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t5_abort_valid", 32'(out_valid), 32'd0);
    check("t5_abort_word", out_word, 32'd0);
    tick();
    base = log_w.size();
    drive_feature(C'(3), C'(2), d, 1'b1);
    drain(100);
    check("t5_count", 32'(log_w.size() - base), 32'd10);
    check("t5_word0", log_w[base], 32'h00000803);
    check("t5_trailer", log_w[base+9], 32'hA5000001);

    // random traffic with random stalls
    do_reset(2);
    for (int c = 0; c < 3000; c++) begin
      out_ready     = ($urandom_range(0, 99) < 60);
      in_valid      = $urandom_range(0, 1) == 1;
      in_frame_end  = ($urandom_range(0, 15) == 0) && (level < DEPTH);
      in_feature_x  = C'($urandom_range(0, 1023));
      in_feature_y  = C'($urandom_range(0, 1023));
      rand_desc(in_descriptor);
      tick();
    end
    in_valid     = 1'b0;
    in_frame_end = 1'b0;
    drain(3000);
    check("random_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
